// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer
// Wraps a parallel payload into a complete SD command frame and shifts it out
// on the CMD line: start bit (0), transmission bit (1), payload, optional CRC7,
// end bit (1). Handshake toward the command FSM is a 4-phase iEnable/oComplete
// exchange; a frame runs to completion unless iReset is asserted.
//
// Ports
//   iSD_clock  : single clock, all state changes on the rising edge
//   iReset     : asynchronous, active-high reset
//   iEnable    : frame request, only looked at while idle
//   iParallel  : payload, captured on the accepting edge
//   oSerial    : registered CMD-line bit
//   oComplete  : frame finished, held until iEnable goes low
//   oBusy      : high while frame bits are on the line
module sd_cmd_serializer #(
  parameter int DATA_WIDTH = 38,
  parameter bit CRC_ENABLE = 1'b1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  iSD_clock,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic [DATA_WIDTH-1:0] iParallel,
  output logic                  oSerial,
  output logic                  oComplete,
  output logic                  oBusy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Each state names what is currently being driven on the line, so the
  // registered output and the state always describe the same cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TXBIT,
    S_DATA,
    S_CRC,
    S_END,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [2:0]            crcCnt_q;
  logic [6:0]            crc_q;
  logic                  serial_q;
  logic                  complete_q;
  logic                  busy_q;

  logic                  dataBit_d;
  logic [DATA_WIDTH-1:0] shift_d;

  // CRC7 (x^7 + x^3 + 1), one bit per call.
  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic bitIn);
    logic fb;
    fb = bitIn ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Next payload bit to drive and the shift register after it leaves.
  assign dataBit_d = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  assign oSerial   = serial_q;
  assign oComplete = complete_q;
  assign oBusy     = busy_q;

  // Frame sequencer. Every bit is loaded into serial_q on the edge before the
  // cycle it occupies, and the CRC absorbs it at that same edge. The start bit
  // is 0 into a cleared CRC, so clearing on acceptance is already correct.
  // The CRC register is frozen while its bits are sent; crcCnt_q indexes it.
  always_ff @(posedge iSD_clock or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      crcCnt_q   <= '0;
      crc_q      <= '0;
      serial_q   <= IDLE_LEVEL;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          serial_q   <= IDLE_LEVEL;
          complete_q <= 1'b0;
          busy_q     <= 1'b0;
          if (iEnable) begin
            state_q  <= S_START;
            shift_q  <= iParallel;
            crc_q    <= '0;
            bitCnt_q <= '0;
            crcCnt_q <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          state_q  <= S_TXBIT;
          serial_q <= 1'b1;
          crc_q    <= crc7Step(crc_q, 1'b1);
        end
        S_TXBIT: begin
          state_q  <= S_DATA;
          serial_q <= dataBit_d;
          crc_q    <= crc7Step(crc_q, dataBit_d);
          shift_q  <= shift_d;
          bitCnt_q <= '0;
        end
        S_DATA: begin
          if (bitCnt_q == LAST_BIT) begin
            if (CRC_ENABLE) begin
              state_q  <= S_CRC;
              serial_q <= crc_q[6];
              crcCnt_q <= 3'd1;
            end else begin
              state_q  <= S_END;
              serial_q <= 1'b1;
            end
          end else begin
            serial_q <= dataBit_d;
            crc_q    <= crc7Step(crc_q, dataBit_d);
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_q + CNT_W'(1);
          end
        end
        S_CRC: begin
          if (crcCnt_q == 3'd7) begin
            state_q  <= S_END;
            serial_q <= 1'b1;
          end else begin
            serial_q <= crc_q[3'd6 - crcCnt_q];
            crcCnt_q <= crcCnt_q + 3'd1;
          end
        end
        S_END: begin
          state_q    <= S_DONE;
          serial_q   <= IDLE_LEVEL;
          busy_q     <= 1'b0;
          complete_q <= 1'b1;
        end
        S_DONE: begin
          // Holding iEnable high keeps us here; no retrigger without a low phase.
          if (!iEnable) begin
            state_q    <= S_IDLE;
            complete_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          serial_q   <= IDLE_LEVEL;
          complete_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// tb_sd_cmd_serializer
// Directed bench for sd_cmd_serializer. Instance A uses the default
// parameters (38-bit payload, CRC7, MSB first); instance B is an 8-bit,
// LSB-first frame without CRC. Expected frames are written out by hand.
module tb_sd_cmd_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enA, enB;
  logic [37:0] parA;
  logic [7:0]  parB;
  logic        serA, compA, busyA;
  logic        serB, compB, busyB;

  int checks = 0;
  int errors = 0;

  logic [63:0] bits;
  int          busyCnt;
  int          bad;

  always #5 clock = ~clock;

  sd_cmd_serializer dutA (
    .iSD_clock (clock),
    .iReset    (reset),
    .iEnable   (enA),
    .iParallel (parA),
    .oSerial   (serA),
    .oComplete (compA),
    .oBusy     (busyA)
  );

  sd_cmd_serializer #(
    .DATA_WIDTH (8),
    .CRC_ENABLE (1'b0),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) dutB (
    .iSD_clock (clock),
    .iReset    (reset),
    .iEnable   (enB),
    .iParallel (parB),
    .oSerial   (serB),
    .oComplete (compB),
    .oBusy     (busyB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1. Raises the request, lets the next edge accept it,
  // then records n line bits (first bit ends up in the MSB of the n-bit field)
  // and the number of cycles oBusy was high. Optionally scrambles the payload
  // input every cycle after acceptance. Leaves the request high.
  task automatic applyStimulus(input bit useB, input logic [37:0] payload, input int n,
                               input bit scramble, output logic [63:0] frame,
                               output int busyCycles);
    if (useB) begin
      parB = payload[7:0];
      enB  = 1'b1;
    end else begin
      parA = payload;
      enA  = 1'b1;
    end
    checkOutput("busy_before_accept", useB ? busyB : busyA, 64'd0);
    @(posedge clock); #1;
    frame      = '0;
    busyCycles = 0;
    for (int i = 0; i < n; i++) begin
      frame = {frame[62:0], (useB ? serB : serA)};
      if (useB ? busyB : busyA) busyCycles++;
      if (scramble) begin
        if (useB) parB = 8'($urandom());
        else      parA = 38'({$urandom(), $urandom()});
      end
      @(posedge clock); #1;
    end
    checkOutput("done_complete", useB ? compB : compA, 64'd1);
    checkOutput("done_busy",     useB ? busyB : busyA, 64'd0);
    checkOutput("done_idle",     useB ? serB  : serA,  64'd1);
  endtask

  // Drops the request; the next edge returns to idle and clears oComplete.
  task automatic releaseEnable(input bit useB);
    if (useB) enB = 1'b0;
    else      enA = 1'b0;
    @(posedge clock); #1;
    checkOutput("release_complete", useB ? compB : compA, 64'd0);
    checkOutput("release_idle",     useB ? serB  : serA,  64'd1);
  endtask

  initial begin
    reset = 1'b1;
    enA   = 1'b0;
    enB   = 1'b0;
    parA  = '0;
    parB  = '0;
    #3;
    checkOutput("reset_serA",  serA,  64'd1);
    checkOutput("reset_busyA", busyA, 64'd0);
    checkOutput("reset_compA", compA, 64'd0);
    checkOutput("reset_serB",  serB,  64'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // CMD0: all-zero payload, CRC 7'h4A
    applyStimulus(1'b0, 38'h0, 48, 1'b0, bits, busyCnt);
    checkOutput("cmd0_frame", bits, {16'h0, 2'b01, 38'h0, 7'h4A, 1'b1});
    checkOutput("cmd0_busy_cycles", 64'(busyCnt), 64'd48);
    releaseEnable(1'b0);

    // CMD8 with argument 0x1AA, CRC 7'h43, last byte 0x87
    applyStimulus(1'b0, {6'd8, 32'h0000_01AA}, 48, 1'b0, bits, busyCnt);
    checkOutput("cmd8_frame", bits, {16'h0, 2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1});
    checkOutput("cmd8_last_byte", 64'(bits[7:0]), 64'h87);
    releaseEnable(1'b0);

    // 8-bit LSB-first frame without CRC: 0,1,1,0,0,0,0,1,0,1,1
    applyStimulus(1'b1, 38'hA1, 11, 1'b0, bits, busyCnt);
    checkOutput("short_frame", bits, 64'b01100001011);
    checkOutput("short_busy_cycles", 64'(busyCnt), 64'd11);
    releaseEnable(1'b1);

    // Reset in the middle of a CMD0 frame (line is 0 at this point)
    parA = '0;
    enA  = 1'b1;
    @(posedge clock); #1;
    repeat (20) begin
      @(posedge clock); #1;
    end
    checkOutput("midframe_bit20", serA, 64'd0);
    reset = 1'b1;
    enA   = 1'b0;
    #1;
    checkOutput("midreset_ser",  serA,  64'd1);
    checkOutput("midreset_busy", busyA, 64'd0);
    checkOutput("midreset_comp", compA, 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("postreset_comp", compA, 64'd0);
    checkOutput("postreset_busy", busyA, 64'd0);
    applyStimulus(1'b0, 38'h0, 48, 1'b0, bits, busyCnt);
    checkOutput("postreset_cmd0_frame", bits, {16'h0, 2'b01, 38'h0, 7'h4A, 1'b1});
    releaseEnable(1'b0);

    // Request held high past completion must not start a second frame
    applyStimulus(1'b0, {6'd8, 32'h0000_01AA}, 48, 1'b0, bits, busyCnt);
    bad = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (!(compA === 1'b1 && busyA === 1'b0 && serA === 1'b1)) bad++;
    end
    checkOutput("hold_no_retrigger", 64'(bad), 64'd0);
    releaseEnable(1'b0);
    // Earliest restart: raised right after the edge that returned to idle
    applyStimulus(1'b0, 38'h0, 48, 1'b0, bits, busyCnt);
    checkOutput("restart_cmd0_frame", bits, {16'h0, 2'b01, 38'h0, 7'h4A, 1'b1});
    releaseEnable(1'b0);

    // Payload input churning during the frame must not leak onto the line
    applyStimulus(1'b0, {6'd8, 32'h0000_01AA}, 48, 1'b1, bits, busyCnt);
    checkOutput("scramble_cmd8_frame", bits, {16'h0, 2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1});
    releaseEnable(1'b0);
    applyStimulus(1'b1, 38'hA1, 11, 1'b1, bits, busyCnt);
    checkOutput("scramble_short_frame", bits, 64'b01100001011);
    releaseEnable(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
